// File: rtl/cnt2note.sv
`default_nettype none
// ============================================================================
// Module   : cnt2note
// Function : Measures the half period of a square wave in clk_i cycles and
//            converts it to the nearest MIDI note via the base-octave table.
// Revision : 1.0  initial release
// ============================================================================
module cnt2note #(
    parameter int BW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic          sig_i,
    output logic [7:0]    note_o,
    output logic          valid_o,
    output logic          note_stb_o,
    output logic [BW-1:0] halfcnt_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEASURE = 3'd1,
        S_NORM    = 3'd2,
        S_SEARCH  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [BW-1:0] C_CNT_MAX = {BW{1'b1}};
    localparam logic [BW-1:0] C_CNT_PRE = {{(BW-1){1'b1}}, 1'b0};
    localparam logic [BW-1:0] C_CNT_ONE = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    C_LAST_IDX = 4'd11;

    function automatic logic [7:0] base_tbl(input logic [3:0] idx);
        case (idx)
            4'd0:    base_tbl = 8'd248;
            4'd1:    base_tbl = 8'd234;
            4'd2:    base_tbl = 8'd221;
            4'd3:    base_tbl = 8'd209;
            4'd4:    base_tbl = 8'd197;
            4'd5:    base_tbl = 8'd186;
            4'd6:    base_tbl = 8'd175;
            4'd7:    base_tbl = 8'd165;
            4'd8:    base_tbl = 8'd156;
            4'd9:    base_tbl = 8'd147;
            4'd10:   base_tbl = 8'd139;
            default: base_tbl = 8'd131;
        endcase
    endfunction

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [BW-1:0]          r_cnt;
    logic [BW-1:0]          r_half;
    logic                   r_armed;
    logic [3:0]             r_shift;
    logic [7:0]             r_mant;
    logic [3:0]             r_idx;
    logic [3:0]             r_best_idx;
    logic [8:0]             r_best_diff;
    logic [7:0]             r_note;
    logic                   r_valid;
    logic                   r_stb;

    logic                   w_edge;
    logic                   w_sat;
    logic                   w_found;
    logic [3:0]             w_shift;
    logic [BW-1:0]          w_shifted;
    logic [7:0]             w_mant;
    logic [7:0]             w_tbl;
    logic [8:0]             w_a;
    logic [8:0]             w_b;
    logic [8:0]             w_diff;
    logic                   w_better;
    logic [3:0]             w_fin_idx;
    logic [7:0]             w_oct;
    logic [7:0]             w_note_raw;
    logic [7:0]             w_note;

    // Input synchronizer; the extra r_prev stage gives a level to compare against.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] ^ r_prev;
    assign w_sat  = (r_cnt == C_CNT_MAX);

    // Smallest octave shift that brings the count into 8 bits.
    always_comb begin
        w_found = 1'b0;
        w_shift = 4'd8;
        for (int k = 8; k >= 0; k--) begin
            if ((r_half >> (k + 8)) == '0) begin
                w_found = 1'b1;
                w_shift = 4'(k);
            end
        end
        w_shifted = r_half >> w_shift;
        w_mant    = w_found ? 8'(w_shifted) : 8'hFF;
    end

    assign w_tbl      = base_tbl(r_idx);
    assign w_a        = {1'b0, r_mant};
    assign w_b        = {1'b0, w_tbl};
    assign w_diff     = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    assign w_better   = (w_diff < r_best_diff);
    assign w_fin_idx  = w_better ? r_idx : r_best_idx;
    assign w_oct      = 8'd8 - {4'd0, r_shift};
    assign w_note_raw = 8'd21 + (w_oct * 8'd12) + {4'd0, w_fin_idx};
    assign w_note     = (w_note_raw > 8'd127) ? 8'd127 : w_note_raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_half      <= '0;
            r_armed     <= 1'b0;
            r_shift     <= 4'd0;
            r_mant      <= 8'd0;
            r_idx       <= 4'd0;
            r_best_idx  <= 4'd0;
            r_best_diff <= 9'h1FF;
            r_note      <= 8'd0;
            r_valid     <= 1'b0;
            r_stb       <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            if (!enable_i) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_armed <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                // The edge cycle itself is the first cycle of the new period.
                if (w_edge) begin
                    r_cnt <= C_CNT_ONE;
                end else if (!w_sat) begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end

                if (!w_edge && (r_cnt == C_CNT_PRE)) begin
                    r_valid <= 1'b0;
                    r_note  <= 8'd0;
                    r_armed <= 1'b0;
                end

                case (r_state)
                    S_IDLE: begin
                        r_state <= S_MEASURE;
                    end
                    S_MEASURE: begin
                        if (w_edge) begin
                            if (r_armed) begin
                                r_half  <= r_cnt;
                                r_state <= S_NORM;
                            end else begin
                                r_armed <= 1'b1;
                            end
                        end
                    end
                    S_NORM: begin
                        r_shift     <= w_shift;
                        r_mant      <= w_mant;
                        r_idx       <= 4'd0;
                        r_best_idx  <= 4'd0;
                        r_best_diff <= 9'h1FF;
                        r_state     <= S_SEARCH;
                    end
                    S_SEARCH: begin
                        if (w_better) begin
                            r_best_diff <= w_diff;
                            r_best_idx  <= r_idx;
                        end
                        r_idx <= r_idx + 4'd1;
                        // Result is registered on the way into DONE so it shows during DONE.
                        if (r_idx == C_LAST_IDX) begin
                            r_note  <= w_note;
                            r_valid <= 1'b1;
                            r_stb   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_MEASURE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign note_o     = r_note;
    assign valid_o    = r_valid;
    assign note_stb_o = r_stb;
    assign halfcnt_o  = r_half;

endmodule
`default_nettype wire

// File: doc/cnt2note.md
Name: cnt2note

Overview:
- Pitch detector: the inverse of the note-to-half-period converter.
- Measures the half period of an incoming square wave in clk_i cycles and converts it to the nearest MIDI note number. It uses the same 12-entry base-octave table and octave-shift scheme as the oscillator path.
- Sits between an external/loopback square-wave input and the MIDI/control logic, for tuner display and loopback self-test of the oscillator chain.

Parameters:
- BW, 16, width of the half-period counter and latched count.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer (minimum 2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  measurement enable; low forces IDLE.
- sig_i  in  1  square wave, asynchronous to clk_i.
- note_o  out  8  detected MIDI note, 21..127.
- valid_o  out  1  high while note_o reflects a signal that is currently present.
- note_stb_o  out  1  one-cycle pulse when note_o is updated.
- halfcnt_o  out  BW  last latched half-period count, for debug.

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0, the synchronizer and counter clear, FSM goes to IDLE, armed flag clears.
- Edge detect:
  - sig_i passes through the SYNC_STAGES synchronizer.
  - An edge cycle is any cycle where the synchronized level differs from the previous one. Both polarities count.
- Counter:
  - Increments every cycle while enable_i=1.
  - On an edge cycle the cycle count since the previous edge is latched as C, and the counter restarts.
  - The counter saturates at 2^BW-1.
- Arming: the first edge after reset, enable rise, or timeout only arms the block. It produces no conversion.
- Timeout: when the counter saturates, valid_o=0, note_o=0, armed clears, and no strobe is issued.
- Table (8-bit), idx 0..11: 248, 234, 221, 209, 197, 186, 175, 165, 156, 147, 139, 131.
- FSM states: IDLE, MEASURE, NORM, SEARCH, DONE.
  - IDLE: entered when enable_i=0. Counter held at 0; valid_o=0. Goes to MEASURE when enable_i=1.
  - MEASURE → NORM on an armed edge; C is latched into halfcnt_o.
  - NORM (1 cycle):
    - s = smallest value in 0..8 with (C>>s) <= 255.
    - If none exists (only possible when BW>16), s=8 and m=255.
    - Otherwise m = C>>s.
  - SEARCH (12 cycles, idx 0..11 in order):
    - Compute |m - table[idx]| as 9-bit unsigned and keep the minimum.
    - Ties go to the lower idx, so the first minimum is kept.
  - DONE (1 cycle):
    - note = 21 + 12*(8-s) + best_idx, clamped to 127.
    - Register note_o, set valid_o=1, pulse note_stb_o, return to MEASURE.
- Latency: edge cycle E → note_o/note_stb_o at E+14.
- Busy edges:
  - Edges during NORM/SEARCH/DONE still latch and restart the counter.
  - They do not start a conversion; that period is discarded.
  - The counter keeps measuring, so the next edge after returning to MEASURE converts normally.
- enable_i falling mid-conversion: abort to IDLE, no strobe, valid_o=0, note_o holds its last value.
- Reset mid-conversion: immediate return to reset values; no strobe.

Test Plan:
- Toggle sig_i with half period 3968 cycles → after arming edge, first note_stb_o 14 cycles after the 2nd synchronized edge; note_o=69, valid_o=1, halfcnt_o=3968.
- Half period 3990 (m=249, s=4) → note_o=69. Half period 3856 (m=241, tie between 248 and 234) → note_o=69, since the lower idx wins.
- Half period 63488 (248<<8) → note_o=21. Half period 131 → computed 128, clamped, note_o=127.
- Stop toggling after lock at 69 → valid_o falls and note_o=0 at the cycle the counter saturates (65535); the next single edge produces no strobe, and the second edge converts.
- Assert rst_i during SEARCH → all outputs 0 immediately, no strobe; after release, the first edge only arms.
- Drop enable_i during NORM → no strobe, valid_o=0. Apply edges spaced 5 cycles during SEARCH → no extra strobes, and the result equals the original period's note.
